serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial mantissa add/subtract sequencer for the floating-point ALU.
- Time-multiplexes one instance of the team's full_adder cell over WIDTH clock cycles, LSB first, instead of instantiating a WIDTH-bit ripple adder.
- Accepts operands through a valid/ready handshake and returns the sum and carry-out through a second valid/ready handshake.
- Sits between the exponent-align stage and the normalise stage of the add path.

Parameters:
- WIDTH, 24, operand/result width in bits (hidden bit + 23-bit fraction); legal range 2..64.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = compute A - B, 0 = compute A + B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, valid while out_valid=1.
- c_out  out  1  final carry; in sub mode, 1 = no borrow (A >= B unsigned).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; shift registers, counter, sum and c_out cleared to 0.
  - out_valid=0, busy=0, in_ready=1 from the first edge sampled with rst_n low.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch A into reg_a; latch (sub ? ~b : b) into reg_b; carry register = sub; bit counter = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, full_adder inputs are reg_a[0], reg_b[0] and the carry register.
  - Cell sum bit shifts into result register MSB (result >> 1 with new bit at [WIDTH-1]).
  - Cell c_out loads the carry register; reg_a and reg_b shift right by 1.
  - Counter increments and is $clog2(WIDTH) bits wide.
  - When counter = WIDTH-1, the current bit is the last: go to DONE. The final carry is c_out.
- DONE:
  - out_valid=1; sum and c_out held stable.
  - On out_ready=1: go to IDLE, out_valid=0 next cycle.
  - No operand accept in the DONE cycle; the earliest next accept is the cycle after returning to IDLE.
- Latency:
  - Accept edge at cycle T; out_valid=1 at cycle T+WIDTH+1 (WIDTH RUN cycles, then DONE).
  - Throughput is 1 operation per WIDTH+2 cycles with out_ready tied high.
- Arithmetic: modulo 2^WIDTH; sub uses two's complement (invert B, carry-in 1). No sign handling; the caller orders magnitudes.
- Boundaries:
  - in_valid while busy: ignored, no state change, operands not sampled.
  - Operands may change after the accept edge without effect.
  - out_ready held low: stay in DONE indefinitely, outputs frozen.
  - out_ready high before out_valid: no effect.
  - Reset in RUN or DONE: operation discarded, IDLE next cycle, out_valid drops the same edge.
  - WIDTH=2: RUN lasts exactly 2 cycles.

Optional Feature:
- Macro: SERIAL_ADD_ZERO_EN.
- Defined:
  - Extra output port zero (1 bit), reset 0.
  - Sticky-OR register cleared on accept and ORed with each cell sum bit during RUN.
  - zero = ~sticky, valid with out_valid; 1 iff sum == 0.
- Undefined: port and register absent; all other behaviour identical.

Test Plan (WIDTH=8):
- A=0x0F, B=0x01, sub=0, accept at T -> out_valid rises at T+9, sum=0x10, c_out=0, busy high T+1..T+9.
- A=0xFF, B=0x01, sub=0 -> sum=0x00, c_out=1. Then A=0x05, B=0x07, sub=1 -> sum=0xFE, c_out=0.
- Hold out_ready=0 for 5 cycles after out_valid -> sum/c_out stable, in_ready=0. In_valid pulses with A=0xAA during RUN and DONE -> ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Start A=0x3C, B=0x11; drive rst_n=0 for one edge at RUN cycle 4 -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1. A new request A=0x01, B=0x02 -> sum=0x03 at accept+9.
- out_ready tied 1, in_valid tied 1, back-to-back ops -> accepts spaced 10 cycles apart, no result lost or duplicated.
- With SERIAL_ADD_ZERO_EN: A=0x33, B=0x33, sub=1 -> sum=0x00, c_out=1, zero=1. A=0x33, B=0x32, sub=1 -> sum=0x01, zero=0.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Optional zero flag present when SERIAL_ADD_ZERO_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADD_ZERO_EN
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, c_out, zero
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial mantissa add/subtract: one full_adder reused over WIDTH cycles, LSB first.
// Define SERIAL_ADD_ZERO_EN to add the zero-result flag.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus,
  output logic            busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             accept;
  logic             fa_s;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == LAST_BIT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: the inverted operand is latched and the
  // carry register is seeded with sub.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.sub ? ~bus.b : bus.b;
      carry_reg <= bus.sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      res_reg   <= {fa_s, res_reg[WIDTH-1:1]};
      carry_reg <= fa_cout;
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign busy          = (state_reg != IDLE);
  assign bus.sum       = res_reg;
  assign bus.c_out     = carry_reg;

`ifdef SERIAL_ADD_ZERO_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_reg <= 1'b0;
    end else if (accept) begin
      sticky_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      sticky_reg <= sticky_reg | fa_s;
    end
  end

  // Gated by DONE so the flag reads 0 out of reset and while running.
  assign bus.zero = (state_reg == DONE) & ~sticky_reg;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised self-checking bench for serial_add_ctrl at WIDTH=8.
// Zero-flag checks compile in when SERIAL_ADD_ZERO_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned arithmetic modulo 2^W.
  function automatic void ref_model(input int av, input int bv, input bit sv,
                                    output logic [W-1:0] r, output logic c);
    int t;
    if (sv) begin
      t = av - bv;
      c = (av >= bv);
    end else begin
      t = av + bv;
      c = (t >= (1 << W));
    end
    r = W'(t & ((1 << W) - 1));
  endfunction

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.sub      = sv;
    wait_clk();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.sub      = 1'($urandom);
  endtask

  // Returns the cycle (1 = first cycle after accept) at which out_valid is seen.
  task automatic wait_valid(input bit junk, output int cyc, output bit busy_ok);
    cyc     = 1;
    busy_ok = (busy === 1'b1);
    while (bus.out_valid !== 1'b1 && cyc < 64) begin
      if (junk) begin
        bus.in_valid = 1'($urandom);
        bus.a        = 8'hAA;
      end
      wait_clk();
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    wait_clk();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk();
    wait_clk();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
    checks++;
    if (bus.sum !== 8'h00 || bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: sum=%h c_out=%b, required 00 0", bus.sum, bus.c_out);
    end
`ifdef SERIAL_ADD_ZERO_EN
    checks++;
    if (bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero: zero=%b, required 0", bus.zero);
    end
`endif
    rst_n = 1'b1;
    wait_clk();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h0F, 8'hFF, 8'h05, 8'h33, 8'h33, 8'h00};
    logic [W-1:0] tb [6] = '{8'h01, 8'h01, 8'h07, 8'h33, 8'h32, 8'h00};
    logic         ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] er;
    logic         ec;
    int           cyc;
    bit           bok;
    for (int i = 0; i < 6; i++) begin
      ref_model(int'(ta[i]), int'(tb[i]), ts[i], er, ec);
      start_op(ta[i], tb[i], ts[i]);
      wait_valid(1'b0, cyc, bok);
      $display("directed op a=%h b=%h sub=%b -> sum=%h c_out=%b at cycle %0d",
               ta[i], tb[i], ts[i], bus.sum, bus.c_out, cyc);
      checks++;
      if (cyc != W + 1 || !bok) begin
        errors++;
        $display("FAIL dir_latency[%0d]: valid at %0d busy_ok=%b, required %0d 1", i, cyc, bok, W + 1);
      end
      checks++;
      if (bus.sum !== er || bus.c_out !== ec) begin
        errors++;
        $display("FAIL dir_result[%0d]: sum=%h c_out=%b, required %h %b", i, bus.sum, bus.c_out, er, ec);
      end
`ifdef SERIAL_ADD_ZERO_EN
      checks++;
      if (bus.zero !== (er == '0)) begin
        errors++;
        $display("FAIL dir_zero[%0d]: zero=%b, required %b", i, bus.zero, (er == '0));
      end
`endif
      finish_op();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dir_return[%0d]: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                 i, bus.in_ready, bus.out_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, er;
    logic         sv, ec, pre;
    int           cyc, hold;
    bit           bok, stable;
    for (int i = 0; i < 16; i++) begin
      av   = W'($urandom);
      bv   = W'($urandom);
      sv   = 1'($urandom);
      pre  = 1'($urandom);
      hold = pre ? 0 : int'($urandom_range(0, 3));
      ref_model(int'(av), int'(bv), sv, er, ec);
      bus.out_ready = pre;
      start_op(av, bv, sv);
      wait_valid(1'b0, cyc, bok);
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        wait_clk();
        if (bus.out_valid !== 1'b1 || bus.sum !== er || bus.c_out !== ec) stable = 1'b0;
      end
      $display("random op a=%h b=%h sub=%b -> sum=%h c_out=%b at cycle %0d hold %0d",
               av, bv, sv, bus.sum, bus.c_out, cyc, hold);
      checks++;
      if (cyc != W + 1 || !bok) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: valid at %0d busy_ok=%b, required %0d 1", i, cyc, bok, W + 1);
      end
      checks++;
      if (bus.sum !== er || bus.c_out !== ec || !stable) begin
        errors++;
        $display("FAIL rnd_result[%0d]: sum=%h c_out=%b stable=%b, required %h %b 1",
                 i, bus.sum, bus.c_out, stable, er, ec);
      end
`ifdef SERIAL_ADD_ZERO_EN
      checks++;
      if (bus.zero !== (er == '0)) begin
        errors++;
        $display("FAIL rnd_zero[%0d]: zero=%b, required %b", i, bus.zero, (er == '0));
      end
`endif
      finish_op();
    end
  endtask

  task automatic test_hold_ignore();
    int cyc;
    bit bok, ok;
    start_op(8'h12, 8'h34, 1'b0);
    wait_valid(1'b1, cyc, bok);
    checks++;
    if (cyc != W + 1 || bus.sum !== 8'h46 || bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_result: cycle=%0d sum=%h c_out=%b, required %0d 46 0", cyc, bus.sum, bus.c_out, W + 1);
    end
    ok = 1'b1;
    for (int h = 0; h < 5; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = 8'hAA;
      wait_clk();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 8'h46 || bus.c_out !== 1'b0)
        ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    $display("hold op a=12 b=34 held 5 cycles -> sum=%h c_out=%b", bus.sum, bus.c_out);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_stable: sum=%h c_out=%b in_ready=%b, required 46 0 0 throughout",
               bus.sum, bus.c_out, bus.in_ready);
    end
    finish_op();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit bok;
    start_op(8'h3C, 8'h11, 1'b0);
    wait_clk();
    wait_clk();
    wait_clk();
    rst_n = 1'b0;
    wait_clk();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.sum !== 8'h00) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b sum=%h, required 1 0 0 00",
               bus.in_ready, bus.out_valid, busy, bus.sum);
    end
    start_op(8'h01, 8'h02, 1'b0);
    wait_valid(1'b0, cyc, bok);
    $display("post-reset op a=01 b=02 -> sum=%h c_out=%b at cycle %0d", bus.sum, bus.c_out, cyc);
    checks++;
    if (cyc != W + 1 || bus.sum !== 8'h03 || bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL midrun_next: cycle=%0d sum=%h c_out=%b, required %0d 03 0", cyc, bus.sum, bus.c_out, W + 1);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    logic [W:0]   q[$];
    logic [W:0]   e;
    logic [W-1:0] er;
    logic         ec;
    int           nres = 0;
    bit           exp_rdy, exp_ov;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 60; k++) begin
      exp_rdy = (k % (W + 2) == 0);
      exp_ov  = (k % (W + 2) == W + 1);
      checks++;
      if (bus.in_ready !== exp_rdy || bus.out_valid !== exp_ov) begin
        errors++;
        $display("FAIL b2b_handshake[%0d]: in_ready=%b out_valid=%b, required %b %b",
                 k, bus.in_ready, bus.out_valid, exp_rdy, exp_ov);
      end
      if (exp_ov && q.size() > 0) begin
        e = q.pop_front();
        nres++;
        $display("b2b result %0d -> sum=%h c_out=%b", nres, bus.sum, bus.c_out);
        checks++;
        if ({bus.c_out, bus.sum} !== e) begin
          errors++;
          $display("FAIL b2b_result[%0d]: c_out,sum=%h, required %h", nres, {bus.c_out, bus.sum}, e);
        end
      end
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.sub = 1'($urandom);
      if (exp_rdy) begin
        ref_model(int'(bus.a), int'(bus.b), bus.sub, er, ec);
        q.push_back({ec, er});
      end
      wait_clk();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (nres != 6 || q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: results=%0d pending=%0d busy=%b, required 6 0 0", nres, q.size(), busy);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
